// File: rtl/debounce_fsm.sv
//==============================================================================
// Module      : debounce_fsm
// Description : Synchronizes and debounces a raw level input. Optional
//               rise/fall pulses are compiled in with macro DEBOUNCE_EDGE_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module debounce_fsm #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic areset_n,
    input  logic in,
    output logic out,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam logic [1:0] S_LOW      = 2'd0;
    localparam logic [1:0] S_CHK_HIGH = 2'd1;
    localparam logic [1:0] S_HIGH     = 2'd2;
    localparam logic [1:0] S_CHK_LOW  = 2'd3;

    localparam logic [7:0] C_LAST_CNT = 8'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_in_sync;
    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic [7:0]             r_cnt;
    logic [7:0]             w_cnt_nxt;
    logic                   r_out;

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], in};
        end
    end

    assign w_in_sync = r_sync[SYNC_STAGES-1];

    // State register; out is taken from the next state so it is a plain flop.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_state <= S_LOW;
            r_cnt   <= 8'd0;
            r_out   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_out   <= (w_state_nxt == S_HIGH) || (w_state_nxt == S_CHK_LOW);
        end
    end

    // A reversal always wins over the terminal count, so a glitch on the
    // final qualifying cycle still aborts.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = 8'd0;
        case (r_state)
            S_LOW: begin
                if (w_in_sync) begin
                    w_state_nxt = S_CHK_HIGH;
                end
            end
            S_CHK_HIGH: begin
                if (!w_in_sync) begin
                    w_state_nxt = S_LOW;
                end else if (r_cnt == C_LAST_CNT) begin
                    w_state_nxt = S_HIGH;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            S_HIGH: begin
                if (!w_in_sync) begin
                    w_state_nxt = S_CHK_LOW;
                end
            end
            S_CHK_LOW: begin
                if (w_in_sync) begin
                    w_state_nxt = S_HIGH;
                end else if (r_cnt == C_LAST_CNT) begin
                    w_state_nxt = S_LOW;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = S_LOW;
            end
        endcase
    end

    always_comb begin
        out  = r_out;
        busy = (r_state == S_CHK_HIGH) || (r_state == S_CHK_LOW);
    end

`ifdef DEBOUNCE_EDGE_EN
    logic r_rise;
    logic r_fall;

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= (r_state == S_CHK_HIGH) && (w_state_nxt == S_HIGH);
            r_fall <= (r_state == S_CHK_LOW) && (w_state_nxt == S_LOW);
        end
    end

    assign rise = r_rise;
    assign fall = r_fall;
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_debounce_fsm.sv
//==============================================================================
// Module      : tb_debounce_fsm
// Description : Self-checking bench for debounce_fsm (SYNC=2, DEBOUNCE=4 and 1).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_debounce_fsm;

    localparam logic [3:0] F  = 4'b1111;
    localparam logic [3:0] NB = 4'b1110;
`ifdef DEBOUNCE_EDGE_EN
    localparam logic EDGE_EN = 1'b1;
`else
    localparam logic EDGE_EN = 1'b0;
`endif

    typedef struct {
        logic       vin;
        logic [3:0] exp;
        logic [3:0] mask;
        string      name;
    } vec_t;

    typedef struct {
        int         sel;
        logic [3:0] exp;
        logic [3:0] mask;
        string      name;
    } sb_t;

    logic clk = 1'b0;
    logic areset_n;
    logic in_a, in_b;
    logic out_a, rise_a, fall_a, busy_a;
    logic out_b, rise_b, fall_b, busy_b;

    vec_t tbl[$];
    sb_t  sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [3:0] v1_exp [9];

    always #5 clk = ~clk;

    debounce_fsm #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) u_dut_a (
        .clk(clk), .areset_n(areset_n), .in(in_a),
        .out(out_a), .rise(rise_a), .fall(fall_a), .busy(busy_a)
    );

    debounce_fsm #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(1)) u_dut_b (
        .clk(clk), .areset_n(areset_n), .in(in_b),
        .out(out_b), .rise(rise_b), .fall(fall_b), .busy(busy_b)
    );

    // Expected vectors are {out, rise, fall, busy}; pulses vanish in the plain build.
    function automatic logic [3:0] fix(input logic [3:0] e);
        return {e[3], e[2] & EDGE_EN, e[1] & EDGE_EN, e[0]};
    endfunction

    function automatic logic [3:0] actual(input int sel);
        if (sel == 0) return {out_a, rise_a, fall_a, busy_a};
        return {out_b, rise_b, fall_b, busy_b};
    endfunction

    function void add(input logic v, input logic [3:0] e, input logic [3:0] m, input string nm);
        tbl.push_back('{vin: v, exp: e, mask: m, name: nm});
    endfunction

    task automatic check(input logic [3:0] act, input logic [3:0] exp,
                         input logic [3:0] mask, input string nm);
        n_cmp++;
        if ((act & mask) !== (exp & mask)) begin
            n_bad++;
            $display("FAIL %s: out/rise/fall/busy got %b expected %b (mask %b) at %0t",
                     nm, act, exp, mask, $time);
        end
    endtask

    task automatic step(input int sel, input logic v, input logic [3:0] e,
                        input logic [3:0] m, input string nm);
        sb_t s;
        if (sel == 0) in_a = v;
        else          in_b = v;
        s.sel  = sel;
        s.exp  = fix(e);
        s.mask = m;
        s.name = nm;
        sb.push_back(s);
        @(posedge clk);
        #1;
        s = sb.pop_front();
        check(actual(s.sel), s.exp, s.mask, s.name);
    endtask

    // Called 1ns after an edge; the next edge after release is edge 1.
    task automatic pulse_reset(input string nm);
        areset_n = 1'b0;
        #1;
        check(actual(0), 4'b0000, F, {nm, "_a"});
        check(actual(1), 4'b0000, F, {nm, "_b"});
        #1;
        areset_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        areset_n = 1'b0;
        in_a     = 1'b0;
        in_b     = 1'b0;
        v1_exp   = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001,
                     4'b0001, 4'b1100, 4'b1000, 4'b1000};

        // V1: held 1 from edge 1 is accepted at edge 7
        for (int i = 0; i < 9; i++) add(1'b1, v1_exp[i], F, "v1_rise");
        // V2: three low cycles from HIGH, aborted
        add(1'b0, 4'b1000, F, "v2_abort"); add(1'b0, 4'b1000, F, "v2_abort");
        add(1'b0, 4'b1001, F, "v2_abort"); add(1'b1, 4'b1001, F, "v2_abort");
        add(1'b1, 4'b1001, F, "v2_abort"); add(1'b1, 4'b1000, F, "v2_abort");
        add(1'b1, 4'b1000, F, "v2_abort");
        // Reversal on the final count cycle of a low check
        add(1'b0, 4'b1000, F, "lastcnt_lo"); add(1'b0, 4'b1000, F, "lastcnt_lo");
        add(1'b0, 4'b1001, F, "lastcnt_lo"); add(1'b0, 4'b1001, F, "lastcnt_lo");
        add(1'b1, 4'b1001, F, "lastcnt_lo"); add(1'b1, 4'b1001, F, "lastcnt_lo");
        add(1'b1, 4'b1000, F, "lastcnt_lo"); add(1'b1, 4'b1000, F, "lastcnt_lo");
        // Held 0 is accepted with a fall pulse
        add(1'b0, 4'b1000, F, "fall"); add(1'b0, 4'b1000, F, "fall");
        add(1'b0, 4'b1001, F, "fall"); add(1'b0, 4'b1001, F, "fall");
        add(1'b0, 4'b1001, F, "fall"); add(1'b0, 4'b1001, F, "fall");
        add(1'b0, 4'b0010, F, "fall"); add(1'b0, 4'b0000, F, "fall");
        add(1'b0, 4'b0000, F, "fall");
        // Reversal on the final count cycle of a high check
        add(1'b1, 4'b0000, F, "lastcnt_hi"); add(1'b1, 4'b0000, F, "lastcnt_hi");
        add(1'b1, 4'b0001, F, "lastcnt_hi"); add(1'b1, 4'b0001, F, "lastcnt_hi");
        add(1'b0, 4'b0001, F, "lastcnt_hi"); add(1'b0, 4'b0001, F, "lastcnt_hi");
        add(1'b0, 4'b0000, F, "lastcnt_hi"); add(1'b0, 4'b0000, F, "lastcnt_hi");
        // V4: toggle every cycle, never accepted
        for (int i = 0; i < 50; i++) add((i % 2) == 0, 4'b0000, NB, "v4_toggle");
        add(1'b0, 4'b0000, NB, "v4_settle"); add(1'b0, 4'b0000, NB, "v4_settle");
        add(1'b0, 4'b0000, F, "v4_settle");  add(1'b0, 4'b0000, F, "v4_settle");

        #2;
        check(actual(0), 4'b0000, F, "reset_a");
        check(actual(1), 4'b0000, F, "reset_b");
        repeat (2) @(posedge clk);
        #1;
        check(actual(0), 4'b0000, F, "reset_held_a");
        areset_n = 1'b1;

        foreach (tbl[i]) begin
            step(0, tbl[i].vin, tbl[i].exp, tbl[i].mask, $sformatf("%s#%0d", tbl[i].name, i));
        end

        // V3: reset mid-check discards qualification, full latency afterwards
        pulse_reset("v3_pre");
        for (int i = 0; i < 5; i++) step(0, 1'b1, v1_exp[i], F, $sformatf("v3_pre#%0d", i));
        pulse_reset("v3_midcheck");
        for (int i = 0; i < 9; i++) step(0, 1'b1, v1_exp[i], F, $sformatf("v3_post#%0d", i));
        pulse_reset("v3_out_async");

        // V5: DEBOUNCE_CYCLES=1 accepts at edge 4, and aborts still win
        for (int i = 0; i < 5; i++) begin
            step(1, 1'b1, (i < 2) ? 4'b0000 : (i == 2) ? 4'b0001 : (i == 3) ? 4'b1100 : 4'b1000,
                 F, $sformatf("v5_rise#%0d", i));
        end
        for (int i = 0; i < 5; i++) begin
            step(1, 1'b0, (i < 2) ? 4'b1000 : (i == 2) ? 4'b1001 : (i == 3) ? 4'b0010 : 4'b0000,
                 F, $sformatf("v5_fall#%0d", i));
        end
        for (int i = 0; i < 5; i++) begin
            step(1, i == 0, (i == 2) ? 4'b0001 : 4'b0000, F, $sformatf("v5_glitch#%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/debounce_fsm.md
DEBOUNCE_FSM -- requirements
Module: debounce_fsm

Interface
REQ-001 The block SHALL be the upstream conditioner for a raw level input; its out port SHALL drive the in port of the downstream Moore state machine.
REQ-002 Parameter SYNC_STAGES, default 2, SHALL set the number of synchronizer flops; legal range 2..4.
REQ-003 Parameter DEBOUNCE_CYCLES, default 16, SHALL set the number of consecutive stable cycles needed to accept a level change; legal range 1..255.
REQ-004 Port clk, input, 1 bit: the single clock; every flop SHALL be rising-edge clocked.
REQ-005 Port areset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port in, input, 1 bit: raw asynchronous level, e.g. switch or pin.
REQ-007 Port out, output, 1 bit: registered debounced level.
REQ-008 Port rise, output, 1 bit: one-cycle pulse when out goes 0->1.
REQ-009 Port fall, output, 1 bit: one-cycle pulse when out goes 1->0.
REQ-010 Port busy, output, 1 bit: high while a candidate level change is being qualified.

Function
REQ-011 in SHALL pass through a SYNC_STAGES-deep flop chain; in_sync is the last stage, and only in_sync SHALL feed the state machine.
REQ-012 The state machine SHALL have four states:
- LOW: stable 0.
- CHK_HIGH: qualifying a 1.
- HIGH: stable 1.
- CHK_LOW: qualifying a 0.
REQ-013 LOW transitions: in_sync=1 -> CHK_HIGH with the counter cleared to 0; otherwise stay in LOW.
REQ-014 CHK_HIGH transitions, in priority order:
- in_sync=0 -> LOW, counter cleared, no output change.
- Else counter==DEBOUNCE_CYCLES-1 -> HIGH.
- Else counter increments.
REQ-015 HIGH and CHK_LOW SHALL mirror REQ-013/REQ-014 with levels inverted.
REQ-016 out SHALL be 1 exactly when state is HIGH or CHK_LOW, registered on the same edge as the state update, so it carries no combinational decode.
REQ-017 rise SHALL be 1 for exactly the one cycle following the CHK_HIGH->HIGH edge; fall likewise for CHK_LOW->LOW; rise and fall SHALL never both be 1.
REQ-018 busy SHALL be 1 exactly when state is CHK_HIGH or CHK_LOW.
REQ-019 Latency: if in changes at or before rising edge 1 and stays stable, out, and rise or fall, SHALL change at edge SYNC_STAGES+DEBOUNCE_CYCLES+1.
REQ-020 Any in_sync reversal during a CHK state, even on the final count cycle, SHALL abort the check: return to the prior stable state, no pulse, counter cleared.
REQ-021 The counter SHALL be 8 bits wide, SHALL never wrap, and SHALL hold 0 in LOW and HIGH.
REQ-022 With DEBOUNCE_CYCLES=1, a level SHALL be accepted after exactly one cycle in the CHK state.

Reset
REQ-023 With areset_n=0, the sync chain, counter, out, rise, fall and busy SHALL clear to 0 and state SHALL be LOW, asynchronously and independent of clk.
REQ-024 Reset asserted mid-check SHALL discard the qualification; after release, a held in=1 SHALL require the full REQ-019 latency again.
REQ-025 The first post-release rising edge SHALL behave as edge 1 of normal operation.

Configuration
REQ-026 Macro DEBOUNCE_EDGE_EN defined SHALL compile in the rise/fall pulse logic per REQ-017.
REQ-027 Without DEBOUNCE_EDGE_EN, rise and fall SHALL remain as ports tied to constant 0 with no flops; out and busy SHALL be unchanged.

Verification
REQ-028 All scenarios use SYNC_STAGES=2 and DEBOUNCE_CYCLES=4 unless stated.
- V1: reset, then in=1 from edge 1 held -> out=1 and rise=1 at edge 7, rise=0 at edge 8, busy high between edges 3 and 7.
- V2: from HIGH, in=0 for 3 cycles then back to 1 -> out stays 1, fall never asserts, busy drops and state returns to HIGH.
- V3: in=1 held, areset_n pulsed low at edge 5 and released before edge 6 -> out=0 immediately; out rises at edge 7 counted from the first post-release edge.
- V4: in toggling every cycle for 50 cycles -> out constant 0, rise and fall never asserted.
- V5: DEBOUNCE_CYCLES=1, in 0->1 at edge 1 -> out=1 at edge 4.
- V6: build without DEBOUNCE_EDGE_EN, rerun V1 -> rise and fall always 0, out timing identical.
